// File: rtl/ps2_device_transmitter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_device_transmitter_if
// Description : Byte request/response handshake plus PS/2 line levels.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_device_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_inhibit;
    logic       tx_ready;
    logic       tx_done;
    logic       ps2_clk_out;
    logic       ps2_data_out;

    modport master (
        output tx_data,
        output tx_valid,
        output host_inhibit,
        input  tx_ready,
        input  tx_done,
        input  ps2_clk_out,
        input  ps2_data_out
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  host_inhibit,
        output tx_ready,
        output tx_done,
        output ps2_clk_out,
        output ps2_data_out
    );
endinterface
`default_nettype wire

// File: rtl/ps2_device_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_device_transmitter
// Description : PS/2 device-to-host frame transmitter with host inhibit/retry.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_device_transmitter #(
    parameter int HALF_PERIOD = 2000,
    parameter int GAP_CYCLES  = 16000
) (
    input  logic                     clk,
    input  logic                     rst,
    ps2_device_transmitter_if.slave  bus_io
);

    localparam int MAX_CNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CNT) > 16) ? $clog2(MAX_CNT) : 16;

    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       c_LAST_IDX  = 4'd10;
    localparam logic [3:0]       c_ABORT_MAX = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_CLK_LOW = 3'd2,
        ST_GAP     = 3'd3,
        ST_INHIBIT = 3'd4
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [3:0]       idx_q,      idx_d;
    logic [10:0]      shift_q,    shift_d;
    logic [7:0]       byte_q,     byte_d;
    logic             clk_out_q,  clk_out_d;
    logic             data_out_q, data_out_d;
    logic             ready_q,    ready_d;
    logic             done_q,     done_d;

    logic w_half_end;
    logic w_gap_end;
    logic w_abort;
    logic w_accept;

    // Frame is stored LSB-first so bit 0 of the shifter is always the line value.
    function automatic logic [10:0] build_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    assign w_half_end = (cnt_q == c_HALF_LAST);
    assign w_gap_end  = (cnt_q == c_GAP_LAST);
    assign w_abort    = bus_io.host_inhibit && (idx_q <= c_ABORT_MAX);
    assign w_accept   = bus_io.tx_valid && ready_q && !bus_io.host_inhibit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        clk_out_d  = clk_out_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_out_d  = 1'b1;
                data_out_d = 1'b1;
                cnt_d      = '0;
                if (w_accept) begin
                    byte_d     = bus_io.tx_data;
                    shift_d    = build_frame(bus_io.tx_data);
                    idx_d      = 4'd0;
                    data_out_d = 1'b0;
                    state_d    = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (w_abort) begin
                    state_d    = ST_INHIBIT;
                    cnt_d      = '0;
                    clk_out_d  = 1'b1;
                    data_out_d = 1'b1;
                end else if (w_half_end) begin
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    state_d   = ST_CLK_LOW;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end

            ST_CLK_LOW: begin
                if (w_abort) begin
                    state_d    = ST_INHIBIT;
                    cnt_d      = '0;
                    clk_out_d  = 1'b1;
                    data_out_d = 1'b1;
                end else if (w_half_end) begin
                    cnt_d     = '0;
                    clk_out_d = 1'b1;
                    if (idx_q == c_LAST_IDX) begin
                        data_out_d = 1'b1;
                        state_d    = ST_GAP;
                    end else begin
                        // Next bit changes together with the rising clock edge.
                        idx_d      = idx_q + 4'd1;
                        shift_d    = {1'b0, shift_q[10:1]};
                        data_out_d = shift_q[1];
                        state_d    = ST_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end

            ST_GAP: begin
                clk_out_d  = 1'b1;
                data_out_d = 1'b1;
                if (w_gap_end) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end

            ST_INHIBIT: begin
                clk_out_d  = 1'b1;
                data_out_d = 1'b1;
                // Any reassertion of inhibit restarts the quiet-time wait.
                if (bus_io.host_inhibit) begin
                    cnt_d = '0;
                end else if (w_gap_end) begin
                    cnt_d      = '0;
                    idx_d      = 4'd0;
                    shift_d    = build_frame(byte_q);
                    data_out_d = 1'b0;
                    state_d    = ST_SETUP;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                clk_out_d  = 1'b1;
                data_out_d = 1'b1;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= 4'd0;
            shift_q    <= 11'd0;
            byte_q     <= 8'd0;
            clk_out_q  <= 1'b1;
            data_out_q <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            clk_out_q  <= clk_out_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign bus_io.tx_ready     = ready_q;
    assign bus_io.tx_done      = done_q;
    assign bus_io.ps2_clk_out  = clk_out_q;
    assign bus_io.ps2_data_out = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_device_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_device_transmitter
// Description : Self-checking bench with a frame-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_device_transmitter;

    localparam int H = 4;
    localparam int G = 8;

    localparam int M_IDLE  = 0;
    localparam int M_FRAME = 1;
    localparam int M_INH   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    ps2_device_transmitter_if bus();

    ps2_device_transmitter #(.HALF_PERIOD(H), .GAP_CYCLES(G)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: frame position k (cycles since start bit) drives both lines.
    int         m_mode = M_IDLE;
    int         m_k    = 0;
    int         m_cnt  = 0;
    logic [7:0] m_byte = 8'd0;
    logic       m_done = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9) return ($countones(b) % 2 == 0);
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= M_IDLE;
            m_k    <= 0;
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            case (m_mode)
                M_IDLE: if (bus.tx_valid && !bus.host_inhibit) begin
                    m_byte <= bus.tx_data;
                    m_mode <= M_FRAME;
                    m_k    <= 0;
                end
                M_FRAME: begin
                    if (m_k < 20*H && bus.host_inhibit) begin
                        m_mode <= M_INH;
                        m_cnt  <= 0;
                    end else if (m_k == 22*H + G - 1) begin
                        m_mode <= M_IDLE;
                        m_done <= 1'b1;
                    end else begin
                        m_k <= m_k + 1;
                    end
                end
                default: begin
                    if (bus.host_inhibit) m_cnt <= 0;
                    else if (m_cnt == G - 1) begin
                        m_mode <= M_FRAME;
                        m_k    <= 0;
                    end else m_cnt <= m_cnt + 1;
                end
            endcase
        end
    end

    logic e_clk, e_data, e_rdy;
    always @(negedge clk) begin
        e_clk  = 1'b1;
        e_data = 1'b1;
        e_rdy  = (m_mode == M_IDLE);
        if (m_mode == M_FRAME && m_k < 22*H) begin
            e_clk  = ((m_k % (2*H)) < H);
            e_data = frame_bit(m_byte, m_k / (2*H));
        end
        chk("ps2_clk_out", bus.ps2_clk_out, e_clk);
        chk("ps2_data_out", bus.ps2_data_out, e_data);
        chk("tx_ready", bus.tx_ready, e_rdy);
        chk("tx_done", bus.tx_done, m_done);
    end

    // Host-side view: data sampled on each falling PS/2 clock edge.
    bit   cap_q[$];
    logic prev_clk = 1'b1;
    int   done_cnt = 0;
    always @(negedge clk) begin
        if (prev_clk && !bus.ps2_clk_out) cap_q.push_back(bus.ps2_data_out);
        prev_clk = bus.ps2_clk_out;
        if (bus.tx_done) done_cnt++;
    end

    task automatic check_frame(input string nm, input logic [10:0] lit);
        logic [10:0] got = '0;
        chk({nm, "_len"}, cap_q.size(), 11);
        for (int i = 0; i < 11 && i < cap_q.size(); i++) got[i] = cap_q[i];
        chk(nm, int'(got), int'(lit));
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        while (!bus.tx_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("send_ready_timeout", 0, 1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.tx_done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.tx_done) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_ready_low();
        int t = 0;
        while (bus.tx_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (bus.tx_ready) chk("accept_timeout", 0, 1);
    endtask

    logic [7:0]  par_bytes [4] = '{8'hF0, 8'h00, 8'h5A, 8'h21};
    logic [10:0] par_lits  [4] = '{11'b11111100000, 11'b11000000000,
                                   11'b11010110100, 11'b11001000010};

    initial begin
        int lat;
        int dc;
        int inh_left;
        bus.tx_data      = 8'd0;
        bus.tx_valid     = 1'b0;
        bus.host_inhibit = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ready", bus.tx_ready, 1);
        chk("rst_clk", bus.ps2_clk_out, 1);
        chk("rst_data", bus.ps2_data_out, 1);
        chk("rst_done", bus.tx_done, 0);
        rst = 1'b0;
        @(negedge clk);

        cap_q.delete();
        send(8'h1C);
        wait_done(lat);
        chk("latency_1C", lat, 96);
        check_frame("frame_1C", 11'b10000111000);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cap_q.delete();
            send(par_bytes[i]);
            wait_done(lat);
            check_frame("frame_parity", par_lits[i]);
        end

        // Back-to-back with tx_valid held high and data changing mid-frame.
        @(negedge clk);
        cap_q.delete();
        bus.tx_data  = 8'h29;
        bus.tx_valid = 1'b1;
        wait_ready_low();
        bus.tx_data = 8'h32;
        wait_done(lat);
        check_frame("frame_29", 11'b10001010010);
        cap_q.delete();
        @(negedge clk);
        wait_ready_low();
        bus.tx_valid = 1'b0;
        wait_done(lat);
        check_frame("frame_32", 11'b10001100100);

        // Inhibit during bit 4, held 20 cycles.
        @(negedge clk);
        dc = done_cnt;
        send(8'h1C);
        repeat (33) @(negedge clk);
        bus.host_inhibit = 1'b1;
        @(negedge clk);
        chk("inh_clk_high", bus.ps2_clk_out, 1);
        chk("inh_data_high", bus.ps2_data_out, 1);
        chk("inh_not_ready", bus.tx_ready, 0);
        repeat (19) @(negedge clk);
        bus.host_inhibit = 1'b0;
        cap_q.delete();
        wait_done(lat);
        chk("inh_resend_latency", lat, 104);
        check_frame("frame_1C_resend", 11'b10000111000);
        @(negedge clk);
        chk("inh_done_count", done_cnt - dc, 1);

        // Inhibit during the stop bit is ignored.
        @(negedge clk);
        dc = done_cnt;
        cap_q.delete();
        send(8'h5A);
        repeat (82) @(negedge clk);
        bus.host_inhibit = 1'b1;
        repeat (4) @(negedge clk);
        bus.host_inhibit = 1'b0;
        wait_done(lat);
        check_frame("frame_5A_stopinh", 11'b11010110100);
        repeat (40) @(negedge clk);
        chk("stopinh_no_retx", cap_q.size(), 11);
        chk("stopinh_ready", bus.tx_ready, 1);
        chk("stopinh_done_count", done_cnt - dc, 1);

        // Asynchronous reset mid-frame (clock line is low at this point).
        @(negedge clk);
        dc = done_cnt;
        send(8'hF0);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_clk", bus.ps2_clk_out, 1);
        chk("arst_data", bus.ps2_data_out, 1);
        chk("arst_ready", bus.tx_ready, 1);
        chk("arst_done", bus.tx_done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("arst_no_done", done_cnt - dc, 0);
        cap_q.delete();
        send(8'h0C);
        wait_done(lat);
        chk("latency_0C", lat, 96);
        check_frame("frame_0C", 11'b11000011000);

        // Randomized traffic with sporadic inhibit bursts.
        inh_left = 0;
        repeat (2500) begin
            @(negedge clk);
            bus.tx_valid = ($urandom_range(0, 2) == 0);
            bus.tx_data  = 8'($urandom);
            if (inh_left > 0) inh_left--;
            else if ($urandom_range(0, 149) == 0) inh_left = $urandom_range(1, 30);
            bus.host_inhibit = (inh_left > 0);
        end
        bus.tx_valid     = 1'b0;
        bus.host_inhibit = 1'b0;
        repeat (200) @(negedge clk);
        chk("final_idle", bus.tx_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_device_transmitter.md
PS2_DEVICE_TRANSMITTER -- requirements
Module: ps2_device_transmitter

Interface
REQ-001 Parameter HALF_PERIOD, default 2000: system-clock cycles per PS/2 clock half period (40 us at 50 MHz, about 12.5 kHz).
REQ-002 Parameter GAP_CYCLES, default 16000: idle cycles after the stop bit, and after an inhibit release, before the next frame may start.
REQ-003 Port clk, input, 1: system clock; all logic is rising-edge triggered.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port tx_data, input, 8: scancode byte to transmit.
REQ-006 Port tx_valid, input, 1: request to send tx_data.
REQ-007 Port host_inhibit, input, 1: host holding the PS/2 clock low; already synchronised upstream.
REQ-008 Port tx_ready, output, 1: block idle and able to accept a byte.
REQ-009 Port tx_done, output, 1: one-cycle pulse when a frame completes.
REQ-010 Port ps2_clk_out, output, 1: device-driven PS/2 clock level (1 = released/high).
REQ-011 Port ps2_data_out, output, 1: device-driven PS/2 data level (1 = released/high).

Function
REQ-012 Frame: 11 bits, in order: start 0, data bits 0..7 (LSB first), odd parity (~^tx_data), stop 1.
REQ-013 States: IDLE, SETUP, CLK_LOW, GAP, INHIBIT.
REQ-014 IDLE: ps2_clk_out=1, ps2_data_out=1, tx_ready=1.
REQ-015 Accept: tx_valid & tx_ready & ~host_inhibit latches tx_data into an 11-bit shift register, clears the bit index, and moves to SETUP; on the next cycle tx_ready=0 and ps2_data_out=0 (start bit).
REQ-016 SETUP: ps2_clk_out=1; ps2_data_out = current bit; lasts HALF_PERIOD cycles; then goes to CLK_LOW.
REQ-017 CLK_LOW: ps2_clk_out=0; data held stable; lasts HALF_PERIOD cycles.
REQ-018 End of CLK_LOW: if bit index < 10, increment the index, shift, and return to SETUP; the next bit appears together with the clock rising edge.
REQ-019 End of CLK_LOW: if bit index = 10, go to GAP.
REQ-020 Timing: each bit spans 2*HALF_PERIOD cycles; the first falling edge of ps2_clk_out occurs HALF_PERIOD cycles after the start bit is driven; a frame is 22*HALF_PERIOD cycles.
REQ-021 GAP: both lines 1 for GAP_CYCLES cycles; then tx_done pulses high for one cycle and the state returns to IDLE, with tx_ready=1 in the same cycle.
REQ-022 tx_valid while tx_ready=0: ignored; tx_data changes mid-frame have no effect.
REQ-023 tx_valid & host_inhibit in IDLE: not accepted; tx_ready stays 1.
REQ-024 Inhibit mid-frame: host_inhibit=1 in SETUP or CLK_LOW with bit index <= 9 aborts the frame.
REQ-025 On abort, the next cycle has ps2_clk_out=1, ps2_data_out=1, state INHIBIT, the latched byte kept, and no tx_done.
REQ-026 Inhibit during the stop bit (index 10): ignored; the frame completes normally.
REQ-027 INHIBIT: wait while host_inhibit=1; after it deasserts, wait GAP_CYCLES cycles, then retransmit the same byte from the start bit (enter SETUP).
REQ-028 host_inhibit reasserted during the post-inhibit wait restarts that wait.
REQ-029 Counters: one phase counter of at least 16 bits compares against (parameter-1) and wraps to 0; a 4-bit bit index covers 0..10.
REQ-030 ps2_clk_out and ps2_data_out are driven directly from flops, with no glitches.

Reset
REQ-031 rst=1 forces IDLE immediately: ps2_clk_out=1, ps2_data_out=1, tx_ready=1, tx_done=0, counters and shift register 0.
REQ-032 rst asserted mid-frame abandons the frame with no retransmit and no tx_done; after release, the first accept takes effect on the first clk edge.

Verification (HALF_PERIOD=4, GAP_CYCLES=8 for simulation)
REQ-033 Send 0x1C -> data sampled on the 11 ps2_clk_out falling edges = 0,0,0,1,1,1,0,0,0,0,1; one tx_done 22*4+8 cycles after accept.
REQ-034 Send 0xF0, then 0x00 -> parity bit 1 in both frames; frames 0x5A and 0x21 also give parity 1 and match their data bits.
REQ-035 Back-to-back: tx_valid held high with 0x29 then 0x32 -> two complete frames separated by at least 8 idle-high cycles; tx_valid pulses during the first frame do not corrupt it.
REQ-036 Inhibit: host_inhibit high for 20 cycles during bit 4 of 0x1C -> lines high within 1 cycle, no tx_done; after release plus 8 cycles, 0x1C is resent in full and tx_done pulses once.
REQ-037 Inhibit during the stop bit -> the frame completes, tx_done pulses, and there is no retransmit.
REQ-038 rst pulsed mid-frame -> lines high and tx_ready=1 asynchronously; no tx_done; a subsequent 0x0C frame is correct (parity 1).
